// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the frame-buffer SRAM arbiter.
package fb_arb_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int unsigned DISPLAY_PORT = 0;

  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned ADDR_W_DEF     = 16;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned RD_LAT_DEF     = 2;
  localparam int unsigned HP_MAX_RUN_DEF = 8;

  // Wide enough for any sensible requester count.
  localparam int unsigned TAG_PORT_W = 8;

  // Tracks one outstanding read on its way back from the SRAM.
  typedef struct packed {
    logic                  valid;
    logic [TAG_PORT_W-1:0] port;
  } rd_tag_t;

endpackage

// File: rtl/fb_mem_arbiter_if.sv
// Requester and SRAM bus of the frame-buffer arbiter.
// slave = arbiter side; master = requesters plus SRAM.
interface fb_mem_arbiter_if
  import fb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
);
  localparam int unsigned NB = DATA_W / 8;

  logic [NUM_REQ-1:0]        req_rts;
  logic [NUM_REQ-1:0]        req_rtr;
  logic [NUM_REQ-1:0]        req_op;
  logic [NUM_REQ*NB-1:0]     req_wben;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [DATA_W-1:0]         req_rdata;
  logic [NUM_REQ-1:0]        req_xfc;

  logic                      mem_en;
  logic [NB-1:0]             mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req_rts, req_op, req_wben, req_addr, req_data, mem_rdata,
    output req_rtr, req_rdata, req_xfc, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_rts, req_op, req_wben, req_addr, req_data, mem_rdata,
    input  req_rtr, req_rdata, req_xfc, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/fb_rr_picker.sv
// Round-robin one-hot picker over the low-priority ports 1..NUM_REQ-1.
// Search starts at ptr_i and wraps from NUM_REQ-1 back to 1.
module fb_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:1] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:1] gnt_o
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk the ring from the pointer and take the first requester.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ - 1; off++) begin
      sum = {1'b0, ptr_i} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ - 1);
      idx = sum[PTR_W-1:0];
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Frame-buffer SRAM arbiter: display port 0 has priority with a bounded run,
// draw ports share the rest round-robin. One registered beat per cycle.
module fb_mem_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned RD_LAT     = RD_LAT_DEF,
  parameter int unsigned HP_MAX_RUN = HP_MAX_RUN_DEF
) (
  input logic             clk,
  input logic             rst_,
  fb_mem_arbiter_if.slave bus
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned RUN_W = $clog2(HP_MAX_RUN + 1);

  logic [NUM_REQ-1:1] lp_req, lp_gnt;
  logic               lp_any, hp_win;
  logic [NUM_REQ-1:0] gnt, xfc;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [RUN_W-1:0]   hp_run_q, hp_run_d;
  logic               mem_en_q, mem_en_d;
  logic [NB-1:0]      mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  rd_tag_t            iss_tag_q, iss_tag_d;
  rd_tag_t            tag_q [RD_LAT];
  rd_tag_t            tag_d [RD_LAT];

  assign lp_req = bus.req_rts[NUM_REQ-1:1];
  assign lp_any = |lp_req;

  fb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i (lp_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (lp_gnt)
  );

  // Port 0 yields only once its run is used up and a draw port is waiting.
  assign hp_win = bus.req_rts[DISPLAY_PORT] &&
                  !(hp_run_q == RUN_W'(HP_MAX_RUN) && lp_any);

  // Grant decode; held at zero while in reset.
  always_comb begin
    gnt = '0;
    if (rst_) begin
      if (hp_win) gnt[DISPLAY_PORT] = 1'b1;
      else        gnt[NUM_REQ-1:1]  = lp_gnt;
    end
  end

  assign bus.req_rtr = gnt;

  // Fairness state: display run length and round-robin pointer.
  always_comb begin
    hp_run_d = hp_run_q;
    rr_ptr_d = rr_ptr_q;
    if (!lp_any) begin
      hp_run_d = '0;
    end else if (gnt[DISPLAY_PORT]) begin
      if (hp_run_q != RUN_W'(HP_MAX_RUN)) hp_run_d = hp_run_q + 1'b1;
    end else begin
      hp_run_d = '0;
    end
    for (int unsigned k = 1; k < NUM_REQ; k++) begin
      if (gnt[k]) rr_ptr_d = (k == NUM_REQ - 1) ? PTR_W'(1) : PTR_W'(k + 1);
    end
  end

  // Issue stage: capture the granted beat; addr/wdata hold when idle.
  always_comb begin
    mem_en_d    = |gnt;
    mem_we_d    = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    iss_tag_d   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mem_addr_d  = bus.req_addr[i*ADDR_W +: ADDR_W];
        mem_wdata_d = bus.req_data[i*DATA_W +: DATA_W];
        if (bus.req_op[i] == OP_WRITE) begin
          mem_we_d = bus.req_wben[i*NB +: NB];
        end else begin
          iss_tag_d.valid = 1'b1;
          iss_tag_d.port  = TAG_PORT_W'(i);
        end
      end
    end
  end

  // Read tags follow the SRAM latency so xfc lines up with mem_rdata.
  always_comb begin
    tag_d[0] = iss_tag_q;
    for (int unsigned i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
  end

  // Return strobe decode from the last tag stage.
  always_comb begin
    xfc = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      xfc[i] = tag_q[RD_LAT-1].valid && (tag_q[RD_LAT-1].port == TAG_PORT_W'(i));
    end
  end

  assign bus.req_xfc   = xfc;
  assign bus.req_rdata = (|xfc) ? bus.mem_rdata : '0;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // State registers; reset drops any reads still in flight.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rr_ptr_q    <= PTR_W'(1);
      hp_run_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      iss_tag_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      hp_run_q    <= hp_run_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      iss_tag_q   <= iss_tag_d;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model of grants, issue beats and read returns.
module tb_fb_mem_arbiter;
  import fb_arb_pkg::*;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned HP_MAX_RUN = 8;
  localparam int unsigned NB         = DATA_W / 8;

  logic clk  = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  fb_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_mem_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_LAT     (RD_LAT),
    .HP_MAX_RUN (HP_MAX_RUN)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  // SRAM environment: byte-lane writes, reads appear RD_LAT cycles after mem_en.
  logic [DATA_W-1:0] sram    [256] = '{default: '0};
  logic [DATA_W-1:0] rd_pipe [RD_LAT] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_en) begin
      for (int b = 0; b < NB; b++)
        if (bus.mem_we[b]) sram[bus.mem_addr[7:0]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
    end
    rd_pipe[0] <= (bus.mem_en && bus.mem_we == '0) ? sram[bus.mem_addr[7:0]] : '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  // Reference model state.
  typedef struct {int due; int port; logic [DATA_W-1:0] data;} ret_t;
  ret_t              rq[$];
  logic [DATA_W-1:0] shadow [256] = '{default: '0};
  int m_ptr = 1, m_run = 0, cyc = 0, last_gnt = -1;
  int tests = 0, fails = 0;
  logic              exp_en = 1'b0;
  logic [NB-1:0]     exp_we = '0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_wdata = '0;

  int                 hist_gnt  [4096];
  logic [NUM_REQ-1:0] hist_rtr  [4096];
  logic [NUM_REQ-1:0] hist_xfc  [4096];
  logic [DATA_W-1:0]  hist_rd   [4096];
  logic               hist_en   [4096];
  logic [NB-1:0]      hist_we   [4096];
  logic [ADDR_W-1:0]  hist_addr [4096];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Who should win this cycle, straight from the priority rules.
  function automatic int pick(logic [NUM_REQ-1:0] rts);
    bit others;
    others = (rts >> 1) != 0;
    if (rts[0] && !(m_run == int'(HP_MAX_RUN) && others)) return 0;
    for (int s = 0; s < NUM_REQ - 1; s++) begin
      int p;
      p = 1 + (m_ptr - 1 + s) % (NUM_REQ - 1);
      if (rts[p]) return p;
    end
    return -1;
  endfunction

  task automatic set_port(input int p, input logic rts, input logic op,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input logic [NB-1:0] wben);
    bus.req_rts[p]                   = rts;
    bus.req_op[p]                    = op;
    bus.req_addr[p*ADDR_W +: ADDR_W] = addr;
    bus.req_data[p*DATA_W +: DATA_W] = data;
    bus.req_wben[p*NB +: NB]         = wben;
  endtask

  task automatic idle_inputs();
    bus.req_rts = '0;
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle, steps the model.
  task automatic cycle();
    int g;
    bit others;
    logic [NUM_REQ-1:0] exp_rtr, exp_xfc;
    logic [DATA_W-1:0]  exp_rd, d;
    logic [ADDR_W-1:0]  a;
    logic [NB-1:0]      wb;
    #4;
    others  = (bus.req_rts >> 1) != 0;
    g       = pick(bus.req_rts);
    exp_rtr = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
    chk("rtr", 64'(bus.req_rtr), 64'(exp_rtr));
    chk("mem_en", 64'(bus.mem_en), 64'(exp_en));
    chk("mem_we", 64'(bus.mem_we), 64'(exp_we));
    chk("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
    chk("mem_wdata", 64'(bus.mem_wdata), 64'(exp_wdata));
    exp_xfc = '0;
    exp_rd  = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_xfc = NUM_REQ'(1) << rq[0].port;
      exp_rd  = rq[0].data;
      void'(rq.pop_front());
    end
    chk("xfc", 64'(bus.req_xfc), 64'(exp_xfc));
    if (exp_xfc != '0) chk("rdata", 64'(bus.req_rdata), 64'(exp_rd));
    hist_gnt[cyc]  = g;
    hist_rtr[cyc]  = bus.req_rtr;
    hist_xfc[cyc]  = bus.req_xfc;
    hist_rd[cyc]   = bus.req_rdata;
    hist_en[cyc]   = bus.mem_en;
    hist_we[cyc]   = bus.mem_we;
    hist_addr[cyc] = bus.mem_addr;
    if (g >= 0) begin
      a  = bus.req_addr[g*ADDR_W +: ADDR_W];
      d  = bus.req_data[g*DATA_W +: DATA_W];
      wb = bus.req_wben[g*NB +: NB];
      exp_en    = 1'b1;
      exp_addr  = a;
      exp_wdata = d;
      if (bus.req_op[g]) begin
        exp_we = wb;
        for (int b = 0; b < NB; b++) if (wb[b]) shadow[a[7:0]][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        exp_we = '0;
        rq.push_back('{due: cyc + RD_LAT + 1, port: g, data: shadow[a[7:0]]});
      end
    end else begin
      exp_en = 1'b0;
      exp_we = '0;
    end
    if (g == 0 && others) m_run = (m_run < int'(HP_MAX_RUN)) ? m_run + 1 : m_run;
    else if (g > 0 || !others) m_run = 0;
    if (g > 0) m_ptr = g % (NUM_REQ - 1) + 1;
    last_gnt = g;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Assert reset at posedge+1, check outputs clear at once, release a cycle later.
  task automatic do_reset();
    rst_ = 1'b0;
    #1;
    chk("rst_rtr", 64'(bus.req_rtr), 64'(0));
    chk("rst_xfc", 64'(bus.req_xfc), 64'(0));
    chk("rst_rdata", 64'(bus.req_rdata), 64'(0));
    chk("rst_mem_en", 64'(bus.mem_en), 64'(0));
    chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
    m_ptr = 1; m_run = 0; last_gnt = -1; rq.delete();
    exp_en = 1'b0; exp_we = '0; exp_addr = '0; exp_wdata = '0;
    @(posedge clk);
    #1;
    cyc++;
    chk("rst_rtr_held", 64'(bus.req_rtr), 64'(0));
    rst_ = 1'b1;
  endtask

  initial begin
    int s, cnt;
    int rr_exp [6];
    logic [NUM_REQ-1:0] any_xfc;
    rr_exp = '{1, 2, 3, 1, 2, 3};
    bus.req_rts = '0; bus.req_op = '0; bus.req_wben = '0;
    bus.req_addr = '0; bus.req_data = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Round robin among draw ports from a fresh pointer.
    for (int p = 1; p < NUM_REQ; p++)
      set_port(p, 1'b1, OP_WRITE, ADDR_W'(16'h0020 + p), 32'h1000_0000 + p, 4'hF);
    s = cyc;
    for (int i = 0; i < 6; i++) cycle();
    idle_cycles(1);
    for (int i = 0; i < 6; i++) begin
      chk("rr_order", 64'(hist_gnt[s+i]), 64'(rr_exp[i]));
      chk("rr_mem_en", 64'(hist_en[s+i+1]), 64'(1));
    end

    // Single write.
    s = cyc;
    set_port(1, 1'b1, OP_WRITE, 16'h0010, 32'h0000_0F0F, 4'h3);
    cycle();
    idle_cycles(1);
    chk("wr_rtr", 64'(hist_rtr[s]), 64'(4'b0010));
    chk("wr_mem_en", 64'(hist_en[s+1]), 64'(1));
    chk("wr_mem_we", 64'(hist_we[s+1]), 64'(4'h3));
    chk("wr_mem_addr", 64'(hist_addr[s+1]), 64'(16'h0010));

    // Read latency.
    s = cyc;
    set_port(2, 1'b1, OP_READ, 16'h0010, 32'h0, 4'h0);
    cycle();
    idle_cycles(4);
    chk("rd_mem_en", 64'(hist_en[s+1]), 64'(1));
    chk("rd_early", 64'(hist_xfc[s+2]), 64'(0));
    chk("rd_xfc", 64'(hist_xfc[s+3]), 64'(4'b0100));
    chk("rd_data", 64'(hist_rd[s+3]), 64'(32'h0000_0F0F));

    // Overlap: read, write, read of the same address.
    s = cyc;
    set_port(3, 1'b1, OP_READ, 16'h0030, 32'h0, 4'h0);
    cycle();
    idle_inputs();
    set_port(1, 1'b1, OP_WRITE, 16'h0030, 32'hCAFE_F00D, 4'hF);
    cycle();
    idle_inputs();
    set_port(3, 1'b1, OP_READ, 16'h0030, 32'h0, 4'h0);
    cycle();
    idle_cycles(5);
    chk("ovl_xfc1", 64'(hist_xfc[s+3]), 64'(4'b1000));
    chk("ovl_rd1", 64'(hist_rd[s+3]), 64'(0));
    chk("ovl_xfc2", 64'(hist_xfc[s+5]), 64'(4'b1000));
    chk("ovl_rd2", 64'(hist_rd[s+5]), 64'(32'hCAFE_F00D));

    // Starvation cap: port 1 gets every ninth grant.
    idle_cycles(2);
    s = cyc;
    set_port(0, 1'b1, OP_READ, 16'h0005, 32'h0, 4'h0);
    set_port(1, 1'b1, OP_WRITE, 16'h0006, 32'h1234_5678, 4'hF);
    for (int i = 0; i < 18; i++) cycle();
    idle_cycles(5);
    cnt = 0;
    for (int i = 0; i < 18; i++) if (hist_gnt[s+i] == 1) cnt++;
    chk("starve_cnt", 64'(cnt), 64'(2));
    chk("starve_pos1", 64'(hist_gnt[s+8]), 64'(1));
    chk("starve_pos2", 64'(hist_gnt[s+17]), 64'(1));

    // Reset one cycle after a read transfer.
    set_port(2, 1'b1, OP_READ, 16'h0010, 32'h0, 4'h0);
    cycle();
    idle_inputs();
    set_port(1, 1'b1, OP_WRITE, 16'h0011, 32'h0, 4'hF);
    do_reset();
    idle_inputs();
    s = cyc;
    idle_cycles(6);
    any_xfc = '0;
    for (int i = 0; i < 6; i++) any_xfc |= hist_xfc[s+i];
    chk("rst_no_xfc", 64'(any_xfc), 64'(0));

    // Random traffic; a waiting requester holds its beat until granted.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NUM_REQ; p++) begin
        if (!(bus.req_rts[p] && last_gnt != p)) begin
          set_port(p, $urandom_range(0, 99) < ((p == 0) ? 60 : 35),
                   1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)),
                   DATA_W'($urandom), NB'($urandom_range(0, 15)));
        end
      end
      cycle();
    end
    idle_cycles(RD_LAT + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
- Shares the single frame-buffer SRAM port between NUM_REQ requesters: the display refresh reader (port 0) and the draw engines (ports 1..NUM_REQ-1), e.g. fill-rect data generator and line engine.
- Each requester uses the rts/rtr/wben/addr/data/op handshake with per-port read-return strobe xfc.
- The arbiter registers one granted beat per cycle onto the SRAM and routes read data back with fixed latency.

Parameters:
- NUM_REQ, 4, number of requester ports (min 2).
- ADDR_W, 16, SRAM word address width.
- DATA_W, 32, data width; byte lanes = DATA_W/8.
- RD_LAT, 2, SRAM cycles from mem_en (read) to mem_rdata valid (>=1).
- HP_MAX_RUN, 8, max consecutive port-0 grants while any other port is requesting.

Ports:
- clk  in  1  clock.
- rst_  in  1  reset; asynchronous, active-low.
- req_rts  in  NUM_REQ  per-port ready-to-send.
- req_rtr  out  NUM_REQ  per-port ready-to-receive (grant); one-hot or zero.
- req_op  in  NUM_REQ  per-port op: 1 = write, 0 = read.
- req_wben  in  NUM_REQ*DATA_W/8  per-port byte write enables (port i at slice i).
- req_addr  in  NUM_REQ*ADDR_W  per-port address.
- req_data  in  NUM_REQ*DATA_W  per-port write data.
- req_rdata  out  DATA_W  read data, broadcast to all ports.
- req_xfc  out  NUM_REQ  one-cycle strobe: req_rdata is valid for that port.
- mem_en  out  1  SRAM access enable.
- mem_we  out  DATA_W/8  SRAM byte write enables; 0 for reads.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after a read's mem_en.

Behaviour:
- Transfer rule: a beat transfers on port i when req_rts[i] & req_rtr[i] in the same cycle. Requesters hold all fields stable while rts is high and not granted.
- req_rtr is combinational from req_rts, rr_ptr and hp_run. No combinational path from rtr back into rts is permitted in requesters.
- Grant priority: port 0 wins when requesting, unless hp_run == HP_MAX_RUN and any port 1..N-1 is requesting. In that case the round-robin winner among 1..N-1 is granted.
- Round robin: search starts at rr_ptr and wraps from N-1 to 1. After a low-priority grant to port k, rr_ptr <= k+1, wrapping N-1 -> 1. rr_ptr is unchanged otherwise.
- hp_run: increments (saturating at HP_MAX_RUN) on a port-0 grant while another port requests. Clears on any low-priority grant or when no other port requests.
- Issue stage: registered. A beat granted in cycle t drives mem_en=1, mem_addr, mem_wdata and mem_we in cycle t+1.
  - mem_we = wben if op=1, else 0.
  - A write with wben=0 still issues and modifies nothing.
- No grant in cycle t: mem_en=0, mem_we=0, and addr/wdata hold their previous values.
- Throughput: one beat per cycle, no bubbles between back-to-back grants, including same-port grants.
- Read return: a read-tag shift pipeline (valid + port index) has depth RD_LAT. A read issued in cycle t+1 raises req_xfc[port]=1 in cycle t+1+RD_LAT, with req_rdata = mem_rdata registered-through.
  - Total latency from transfer to xfc: RD_LAT+1 cycles.
- Return and issue are independent; a new read issues in the same cycle a previous read returns.
- Ordering: strictly in issue order. A read after a write to the same address returns the new data (SRAM write-first not required; issue ordering suffices).
- Reset: all outputs 0 (req_rtr=0, req_xfc=0, req_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0). rr_ptr=1, hp_run=0, tag pipeline invalid.
- Reset mid-operation discards outstanding reads; no xfc is produced for them after release.
- No requests: req_rtr=0 and mem_en=0; pointer and hp_run hold, except hp_run clears per the rule above.

Decomposition:
- Package fb_arb_pkg: OP_READ=0/OP_WRITE=1, DISPLAY_PORT=0, default NUM_REQ/ADDR_W/DATA_W/RD_LAT, and a tag struct {valid, port index}.
- Sub-module fb_rr_picker: combinational round-robin one-hot picker over ports 1..N-1 given request vector and rr_ptr.

Test Plan:
- Single write: port 1 rts, op=1, addr=0x0010, data=0x00000F0F, wben=4'h3 -> rtr[1] same cycle; next cycle mem_en=1, mem_we=4'h3, mem_addr=0x0010.
- Read latency (RD_LAT=2): port 2 reads 0x0010 at cycle 5 -> mem_en at 6; req_xfc[2]=1 at cycle 8 with req_rdata=mem_rdata for 0x0010; other xfc bits 0.
- Round robin: ports 1,2,3 hold rts for 6 cycles -> grant order 1,2,3,1,2,3, one beat per cycle, mem_en high 6 consecutive cycles.
- Starvation cap: ports 0 and 1 hold rts continuously -> 8 grants to port 0, then 1 to port 1, repeating; port 1 gets every 9th grant.
- Reset mid-read: assert rst_ low one cycle after a read transfer -> all outputs 0 immediately; no req_xfc ever asserted for that read.
- Overlap: port 3 read at cycle t, port 1 write at t+1, port 3 read at t+2 of same address -> xfc[3] at t+3 and t+5; second read returns the written data.
